wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 153 +++++++++++++++
 tb/tb_wb_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: retires non-load results at once and holds loads until read data
// returns. A load that waits too long is aborted and reported with a one-cycle error pulse.
module wb_stage #(
   parameter int unsigned LOAD_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   output logic        mem_ready_o,
   input  logic        mem_reg_we_i,
   input  logic [4:0]  mem_reg_waddr_i,
   input  logic [31:0] mem_result_i,
   input  logic        mem_is_load_i,
   input  logic [2:0]  mem_load_funct3_i,
   input  logic [1:0]  mem_addr_lo_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        wb_reg_we_o,
   output logic [4:0]  wb_reg_waddr_o,
   output logic [31:0] wb_reg_wdata_o,
   output logic        wb_busy_o,
   output logic [4:0]  wb_pend_waddr_o,
   output logic        wb_load_err_o
);

   // Handshake: an instruction moves in on a cycle where mem_valid_i and mem_ready_o are both 1;
   // mem_ready_o is 1 exactly while IDLE, so upstream must hold its instruction otherwise.

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        cap_we_q, cap_we_d;
   logic [4:0]  cap_waddr_q, cap_waddr_d;
   logic [2:0]  cap_funct3_q, cap_funct3_d;
   logic [1:0]  cap_addr_lo_q, cap_addr_lo_d;
   logic        we_q, we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic        accept;

   function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo,
                                               input logic [31:0] rdata);
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         3'b000:  return {{24{byte_sel[7]}}, byte_sel};
         3'b100:  return {24'h000000, byte_sel};
         3'b001:  return {{16{half_sel[15]}}, half_sel};
         3'b101:  return {16'h0000, half_sel};
         default: return rdata;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         cap_we_q      <= 1'b0;
         cap_waddr_q   <= 5'd0;
         cap_funct3_q  <= 3'd0;
         cap_addr_lo_q <= 2'd0;
         we_q          <= 1'b0;
         waddr_q       <= 5'd0;
         wdata_q       <= 32'd0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cap_we_q      <= cap_we_d;
         cap_waddr_q   <= cap_waddr_d;
         cap_funct3_q  <= cap_funct3_d;
         cap_addr_lo_q <= cap_addr_lo_d;
         we_q          <= we_d;
         waddr_q       <= waddr_d;
         wdata_q       <= wdata_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cap_we_d      = cap_we_q;
      cap_waddr_d   = cap_waddr_q;
      cap_funct3_d  = cap_funct3_q;
      cap_addr_lo_d = cap_addr_lo_q;
      we_d          = 1'b0;
      waddr_d       = waddr_q;
      wdata_d       = wdata_q;
      err_d         = 1'b0;
      accept        = mem_valid_i && (state_q == IDLE);
      case (state_q)
         IDLE: begin
            if (accept && mem_is_load_i) begin
               cap_we_d      = mem_reg_we_i;
               cap_waddr_d   = mem_reg_waddr_i;
               cap_funct3_d  = mem_load_funct3_i;
               cap_addr_lo_d = mem_addr_lo_i;
               cnt_d         = 8'd0;
               state_d       = LOAD_WAIT;
            end else if (accept && mem_reg_we_i && (mem_reg_waddr_i != 5'd0)) begin
               // Address/data only move on a real write so they hold otherwise.
               we_d    = 1'b1;
               waddr_d = mem_reg_waddr_i;
               wdata_d = mem_result_i;
            end
         end
         LOAD_WAIT: begin
            // Returning data beats the timeout when both land in the same cycle.
            if (dmem_rvalid_i) begin
               state_d = IDLE;
               if (cap_we_q && (cap_waddr_q != 5'd0)) begin
                  we_d    = 1'b1;
                  waddr_d = cap_waddr_q;
                  wdata_d = extend_load(cap_funct3_q, cap_addr_lo_q, dmem_rdata_i);
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_ready_o     = (state_q == IDLE);
      wb_busy_o       = (state_q == LOAD_WAIT);
      wb_pend_waddr_o = (state_q == LOAD_WAIT) ? cap_waddr_q : 5'd0;
      wb_reg_we_o     = we_q;
      wb_reg_waddr_o  = waddr_q;
      wb_reg_wdata_o  = wdata_q;
      wb_load_err_o   = err_q;
   end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random streams, with every register-file
// write checked in order against a queue of expected {waddr, wdata} pairs.
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic        mem_valid_i;
   logic        mem_ready_o;
   logic        mem_reg_we_i;
   logic [4:0]  mem_reg_waddr_i;
   logic [31:0] mem_result_i;
   logic        mem_is_load_i;
   logic [2:0]  mem_load_funct3_i;
   logic [1:0]  mem_addr_lo_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        wb_reg_we_o;
   logic [4:0]  wb_reg_waddr_o;
   logic [31:0] wb_reg_wdata_o;
   logic        wb_busy_o;
   logic [4:0]  wb_pend_waddr_o;
   logic        wb_load_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [36:0] exp_q[$];

   logic       ld_we;
   logic [4:0] ld_wa;
   logic [2:0] ld_f3;
   logic [1:0] ld_lo;

   wb_stage #(.LOAD_TIMEOUT(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_valid_i       (mem_valid_i),
      .mem_ready_o       (mem_ready_o),
      .mem_reg_we_i      (mem_reg_we_i),
      .mem_reg_waddr_i   (mem_reg_waddr_i),
      .mem_result_i      (mem_result_i),
      .mem_is_load_i     (mem_is_load_i),
      .mem_load_funct3_i (mem_load_funct3_i),
      .mem_addr_lo_i     (mem_addr_lo_i),
      .dmem_rvalid_i     (dmem_rvalid_i),
      .dmem_rdata_i      (dmem_rdata_i),
      .wb_reg_we_o       (wb_reg_we_o),
      .wb_reg_waddr_o    (wb_reg_waddr_o),
      .wb_reg_wdata_o    (wb_reg_wdata_o),
      .wb_busy_o         (wb_busy_o),
      .wb_pend_waddr_o   (wb_pend_waddr_o),
      .wb_load_err_o     (wb_load_err_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] d);
      logic [31:0] sh;
      case (f3)
         3'b000: begin sh = d >> (8 * lo); return {{24{sh[7]}}, sh[7:0]}; end
         3'b100: begin sh = d >> (8 * lo); return {24'h0, sh[7:0]}; end
         3'b001: begin sh = d >> (16 * lo[1]); return {{16{sh[15]}}, sh[15:0]}; end
         3'b101: begin sh = d >> (16 * lo[1]); return {16'h0, sh[15:0]}; end
         default: return d;
      endcase
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && wb_reg_we_o === 1'b1) begin
         n_checks++;
         if (wb_reg_waddr_o == 5'd0) begin
            n_fail++;
            $display("FAIL x0_write: got we=1 waddr=0, required no write to x0");
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got waddr=%0d wdata=%h, required no write",
                     wb_reg_waddr_o, wb_reg_wdata_o);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({wb_reg_waddr_o, wb_reg_wdata_o} !== e) begin
               n_fail++;
               $display("FAIL write_data: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                        wb_reg_waddr_o, wb_reg_wdata_o, e[36:32], e[31:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_op(input logic ld, input logic we, input logic [4:0] wa,
                           input logic [31:0] res, input logic [2:0] f3, input logic [1:0] lo);
      mem_valid_i       = 1'b1;
      mem_is_load_i     = ld;
      mem_reg_we_i      = we;
      mem_reg_waddr_i   = wa;
      mem_result_i      = res;
      mem_load_funct3_i = f3;
      mem_addr_lo_i     = lo;
      if (ld) begin
         ld_we = we; ld_wa = wa; ld_f3 = f3; ld_lo = lo;
      end else if (we && wa != 5'd0) begin
         exp_q.push_back({wa, res});
      end
      @(negedge clk);
      mem_valid_i = 1'b0;
   endtask

   task automatic give_rvalid(input logic [31:0] data);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = data;
      if (ld_we && ld_wa != 5'd0) exp_q.push_back({ld_wa, model_ext(ld_f3, ld_lo, data)});
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_checks += 7;
      if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", mem_ready_o); end
      if (wb_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", wb_busy_o); end
      if (wb_pend_waddr_o !== 5'd0) begin n_fail++; $display("FAIL reset_pend: got %0d, required 0", wb_pend_waddr_o); end
      if (wb_reg_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, required 0", wb_reg_we_o); end
      if (wb_reg_waddr_o !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d, required 0", wb_reg_waddr_o); end
      if (wb_reg_wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h, required 0", wb_reg_wdata_o); end
      if (wb_load_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", wb_load_err_o); end
   endtask

   task automatic test_nonload();
      drive_op(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 2'd0);
      n_checks += 4;
      if (wb_reg_we_o !== 1'b1) begin n_fail++; $display("FAIL nl_we: got %b, required 1", wb_reg_we_o); end
      if (wb_reg_waddr_o !== 5'd5) begin n_fail++; $display("FAIL nl_waddr: got %0d, required 5", wb_reg_waddr_o); end
      if (wb_reg_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nl_wdata: got %h, required deadbeef", wb_reg_wdata_o); end
      if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL nl_ready: got %b, required 1", mem_ready_o); end
      drive_op(1'b0, 1'b0, 5'd3, 32'h11111111, 3'd0, 2'd0);
      n_checks += 3;
      if (wb_reg_we_o !== 1'b0) begin n_fail++; $display("FAIL nl_nowe: got %b, required 0", wb_reg_we_o); end
      if (wb_reg_waddr_o !== 5'd5) begin n_fail++; $display("FAIL hold_waddr: got %0d, required 5", wb_reg_waddr_o); end
      if (wb_reg_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_wdata: got %h, required deadbeef", wb_reg_wdata_o); end
   endtask

   task automatic test_x0_guard();
      drive_op(1'b0, 1'b1, 5'd0, 32'hCAFEF00D, 3'd0, 2'd0);
      n_checks += 2;
      if (wb_reg_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b, required 0", wb_reg_we_o); end
      if (wb_reg_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL x0_hold: got %h, required deadbeef", wb_reg_wdata_o); end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 12; i++)
         drive_op(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 3'd0, 2'd0);
      @(negedge clk);
   endtask

   task automatic test_load_ext();
      logic [31:0] exp_v[3];
      logic [2:0]  f3v[3];
      exp_v[0] = 32'hFFFFFF80; exp_v[1] = 32'h00000080; exp_v[2] = 32'h00001280;
      f3v[0] = 3'b000; f3v[1] = 3'b100; f3v[2] = 3'b101;
      for (int k = 0; k < 3; k++) begin
         drive_op(1'b1, 1'b1, 5'(3 + k), 32'd0, f3v[k], 2'd2);
         n_checks++;
         if (wb_pend_waddr_o !== 5'(3 + k)) begin
            n_fail++; $display("FAIL load_pend: got %0d, required %0d", wb_pend_waddr_o, 3 + k);
         end
         repeat (2) @(negedge clk);
         give_rvalid(32'h12803456);
         n_checks += 2;
         if (wb_reg_we_o !== 1'b1) begin n_fail++; $display("FAIL load_we: got %b, required 1", wb_reg_we_o); end
         if (wb_reg_wdata_o !== exp_v[k]) begin
            n_fail++; $display("FAIL load_ext%0d: got %h, required %h", k, wb_reg_wdata_o, exp_v[k]);
         end
      end
      for (int k = 0; k < 16; k++) begin
         drive_op(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'd0,
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         give_rvalid($urandom);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      drive_op(1'b1, 1'b1, 5'd9, 32'd0, 3'b010, 2'd0);
      for (int i = 0; i < 4; i++) begin
         n_checks += 2;
         if (wb_busy_o !== 1'b1) begin n_fail++; $display("FAIL to_busy%0d: got %b, required 1", i, wb_busy_o); end
         if (wb_load_err_o !== 1'b0) begin n_fail++; $display("FAIL to_early_err%0d: got %b, required 0", i, wb_load_err_o); end
         @(negedge clk);
      end
      n_checks += 4;
      if (wb_load_err_o !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b, required 1", wb_load_err_o); end
      if (wb_busy_o !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b, required 0", wb_busy_o); end
      if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b, required 1", mem_ready_o); end
      if (wb_reg_we_o !== 1'b0) begin n_fail++; $display("FAIL to_we: got %b, required 0", wb_reg_we_o); end
      @(negedge clk);
      n_checks++;
      if (wb_load_err_o !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b, required 0", wb_load_err_o); end
      // rvalid on the last allowed wait cycle must still win
      drive_op(1'b1, 1'b1, 5'd9, 32'd0, 3'b010, 2'd0);
      repeat (3) @(negedge clk);
      give_rvalid(32'hA5A5_0F0F);
      n_checks += 2;
      if (wb_load_err_o !== 1'b0) begin n_fail++; $display("FAIL race_err: got %b, required 0", wb_load_err_o); end
      if (wb_reg_we_o !== 1'b1) begin n_fail++; $display("FAIL race_we: got %b, required 1", wb_reg_we_o); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      drive_op(1'b1, 1'b1, 5'd7, 32'd0, 3'b010, 2'd0);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready%0d: got %b, required 0", i, mem_ready_o); end
         @(negedge clk);
      end
      n_checks++;
      if (mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready2: got %b, required 0", mem_ready_o); end
      give_rvalid(32'h0BAD_F00D);
      n_checks += 3;
      if (wb_reg_waddr_o !== 5'd7 || wb_reg_we_o !== 1'b1) begin
         n_fail++; $display("FAIL b2b_x7: got we=%b waddr=%0d, required we=1 waddr=7", wb_reg_we_o, wb_reg_waddr_o);
      end
      if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_wr: got %b, required 1", mem_ready_o); end
      if (wb_reg_wdata_o !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_x7_data: got %h, required 0badf00d", wb_reg_wdata_o); end
      drive_op(1'b0, 1'b1, 5'd8, 32'h8888_0008, 3'd0, 2'd0);
      n_checks++;
      if (wb_reg_waddr_o !== 5'd8 || wb_reg_we_o !== 1'b1) begin
         n_fail++; $display("FAIL b2b_x8: got we=%b waddr=%0d, required we=1 waddr=8", wb_reg_we_o, wb_reg_waddr_o);
      end
      @(negedge clk);
   endtask

   task automatic test_idle_rvalid();
      dmem_rvalid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dmem_rdata_i = $urandom;
         @(negedge clk);
         n_checks += 2;
         if (wb_reg_we_o !== 1'b0) begin n_fail++; $display("FAIL idle_rv_we%0d: got %b, required 0", i, wb_reg_we_o); end
         if (wb_busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_rv_busy%0d: got %b, required 0", i, wb_busy_o); end
      end
      dmem_rvalid_i = 1'b0;
   endtask

   task automatic test_reset_midload();
      drive_op(1'b1, 1'b1, 5'd10, 32'd0, 3'b010, 2'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks += 5;
      if (wb_busy_o !== 1'b0) begin n_fail++; $display("FAIL rml_busy: got %b, required 0", wb_busy_o); end
      if (wb_pend_waddr_o !== 5'd0) begin n_fail++; $display("FAIL rml_pend: got %0d, required 0", wb_pend_waddr_o); end
      if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL rml_ready: got %b, required 1", mem_ready_o); end
      if (wb_reg_wdata_o !== 32'd0) begin n_fail++; $display("FAIL rml_wdata: got %h, required 0", wb_reg_wdata_o); end
      if (wb_reg_waddr_o !== 5'd0) begin n_fail++; $display("FAIL rml_waddr: got %0d, required 0", wb_reg_waddr_o); end
      @(negedge clk);
      rst = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h7777_7777;
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks += 2;
         if (wb_reg_we_o !== 1'b0) begin n_fail++; $display("FAIL rml_we%0d: got %b, required 0", i, wb_reg_we_o); end
         if (wb_load_err_o !== 1'b0) begin n_fail++; $display("FAIL rml_err%0d: got %b, required 0", i, wb_load_err_o); end
         @(negedge clk);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      mem_valid_i = 1'b0; mem_reg_we_i = 1'b0; mem_reg_waddr_i = 5'd0; mem_result_i = 32'd0;
      mem_is_load_i = 1'b0; mem_load_funct3_i = 3'd0; mem_addr_lo_i = 2'd0;
      dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
      ld_we = 1'b0; ld_wa = 5'd0; ld_f3 = 3'd0; ld_lo = 2'd0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_nonload();
      test_x0_guard();
      test_stream();
      test_load_ext();
      test_timeout();
      test_back_to_back();
      test_idle_rvalid();
      test_reset_midload();
      repeat (2) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL drain: got %0d writes outstanding, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
